// File: rtl/elm_pkg.sv
// Shared definitions for the ELM hidden-layer datapath: FSM encodings and default operand widths.
package elm_pkg;

  localparam int ELM_N = 16;
  localparam int ELM_M = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : elm_pkg

// File: rtl/mul_step_unit.sv
// One radix-2 multiply iteration on {acc, Q[, q_m1]}: conditional add/sub of the multiplicand, then shift right.
// BOOTH_SIGNED_EN selects two's-complement Booth recoding; otherwise unsigned shift-add.
module mul_step_unit
  import elm_pkg::*;
#(
  parameter int N = ELM_N,
  parameter int M = ELM_M
) (
  input  logic [N-1:0] i_mcand,
  input  logic [N:0]   i_acc,
  input  logic [M-1:0] i_q,
`ifdef BOOTH_SIGNED_EN
  input  logic         i_q_m1,
  output logic         o_q_m1,
`endif
  output logic [N:0]   o_acc,
  output logic [M-1:0] o_q
);

  logic [N:0] w_sum;

`ifdef BOOTH_SIGNED_EN
  logic [N:0] w_sext;

  assign w_sext = {i_mcand[N-1], i_mcand};

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_q_m1})
      2'b01:   w_sum = i_acc + w_sext;
      2'b10:   w_sum = i_acc - w_sext;
      default: w_sum = i_acc;
    endcase
  end

  // Arithmetic shift: the sign bit of the partial sum refills the top.
  assign o_acc  = {w_sum[N], w_sum[N:1]};
  assign o_q    = {w_sum[0], i_q[M-1:1]};
  assign o_q_m1 = i_q[0];
`else
  // The extra accumulator bit serves as the carry out of the add.
  assign w_sum = i_acc + (i_q[0] ? {1'b0, i_mcand} : '0);

  assign o_acc = {1'b0, w_sum[N:1]};
  assign o_q   = {w_sum[0], i_q[M-1:1]};
`endif

endmodule : mul_step_unit

// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 multiplier, one multiplier bit per clock, start/done handshake; latency M+1 clocks.
// Build option BOOTH_SIGNED_EN: signed Booth radix-2 instead of unsigned shift-add (same ports and timing).
module shift_add_multiplier
  import elm_pkg::*;
#(
  parameter int N = ELM_N,
  parameter int M = ELM_M
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           srst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [M-1:0]   multiplier,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [N+M-1:0] product
);

  localparam int            CW   = $clog2(M + 1);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_mcand;
  logic [N:0]     r_acc;
  logic [N:0]     w_acc_nxt;
  logic [M-1:0]   r_q;
  logic [M-1:0]   w_q_nxt;
  logic [CW-1:0]  r_count;
  logic [N+M-1:0] r_product;
  logic           w_accept;
  logic           w_step;
  logic           w_last;
`ifdef BOOTH_SIGNED_EN
  logic           r_q_m1;
  logic           w_q_m1_nxt;
`endif

  mul_step_unit #(
    .N (N),
    .M (M)
  ) u_step (
    .i_mcand (r_mcand),
    .i_acc   (r_acc),
    .i_q     (r_q),
`ifdef BOOTH_SIGNED_EN
    .i_q_m1  (r_q_m1),
    .o_q_m1  (w_q_m1_nxt),
`endif
    .o_acc   (w_acc_nxt),
    .o_q     (w_q_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || srst) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        ready    = 1'b1;
        w_accept = start;
        if (start) w_state_nxt = CALC;
      end
      CALC: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_count == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        ready       = 1'b1;
        done        = 1'b1;
        w_accept    = start;
        w_state_nxt = start ? CALC : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Product only changes on the final step, so it holds across idle and back-to-back starts.
  always_ff @(posedge clk) begin
    if (rst || srst) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_count   <= '0;
      r_product <= '0;
`ifdef BOOTH_SIGNED_EN
      r_q_m1    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_mcand <= multiplicand;
      r_acc   <= '0;
      r_q     <= multiplier;
      r_count <= '0;
`ifdef BOOTH_SIGNED_EN
      r_q_m1  <= 1'b0;
`endif
    end else if (w_step) begin
      r_acc   <= w_acc_nxt;
      r_q     <= w_q_nxt;
      r_count <= r_count + CW'(1);
`ifdef BOOTH_SIGNED_EN
      r_q_m1  <= w_q_m1_nxt;
`endif
      if (w_last) r_product <= {w_acc_nxt[N-1:0], w_q_nxt};
    end
  end

  assign product = r_product;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier; expected products come from a behavioural multiply via a scoreboard.
// Follows BOOTH_SIGNED_EN to pick the signed or unsigned reference model.
module tb_shift_add_multiplier;
  import elm_pkg::*;

  localparam int N = ELM_N;
  localparam int M = ELM_M;

  logic           clk = 1'b0;
  logic           rst;
  logic           srst;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [M-1:0]   multiplier;
  logic           ready;
  logic           busy;
  logic           done;
  logic [N+M-1:0] product;

  logic [N+M-1:0] sb[$];
  int             n_cmp  = 0;
  int             n_fail = 0;

  shift_add_multiplier #(
    .N (N),
    .M (M)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .srst         (srst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  function automatic logic [N+M-1:0] model(input logic [N-1:0] a, input logic [M-1:0] b);
`ifdef BOOTH_SIGNED_EN
    logic signed [N+M-1:0] sa;
    logic signed [N+M-1:0] sb_v;
    sa   = {{M{a[N-1]}}, a};
    sb_v = {{N{b[M-1]}}, b};
    return sa * sb_v;
`else
    logic [N+M-1:0] ua;
    logic [N+M-1:0] ub;
    ua = {{M{1'b0}}, a};
    ub = {{N{1'b0}}, b};
    return ua * ub;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at a sample point where the DUT is ready; leaves at the sample point of the done cycle
  // (or the cycle after an abort). poke_at/abort_at are cycle offsets after the accepting edge, 0 = unused.
  task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] b,
                        input int poke_at, input int abort_at);
    logic [N+M-1:0] exp_p;
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    sb.push_back(model(a, b));
    tick();
    start        = 1'b0;
    multiplicand = N'($urandom);
    multiplier   = M'($urandom);
    for (int c = 1; c <= M; c++) begin
      check("busy_in_calc", busy, 1);
      check("ready_in_calc", ready, 0);
      start = (c == poke_at);
      if (c == poke_at) begin
        multiplicand = 16'h7777;
        multiplier   = 16'h2222;
      end
      if (c == abort_at) begin
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        exp_p = sb.pop_front();
        return;
      end
      tick();
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("ready_at_done", ready, 1);
    exp_p = sb.pop_front();
    check("product", product, exp_p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    srst         = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_product", product, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);

    // Basic op with exact latency, then the result must hold with no further done pulse.
    run_op(16'd3, 16'd5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_product", product, model(16'd3, 16'd5));
      check("hold_done", done, 0);
      check("hold_ready", ready, 1);
    end

    // Soft clear alone must reproduce the reset state.
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("srst_product", product, 0);
    check("srst_done", done, 0);
    check("srst_busy", busy, 0);
    check("srst_ready", ready, 1);

    // Sign and width corner operands.
    run_op(16'hFFF9, 16'd6, 0, 0);
    tick();
    run_op(16'h8000, 16'h8000, 0, 0);
    tick();
    run_op(16'hFFFF, 16'hFFFF, 0, 0);
    tick();
    run_op(16'h0000, 16'h1234, 0, 0);
    tick();
    run_op(16'h7FFF, 16'h8001, 0, 0);
    tick();

    // A start during CALC must be ignored.
    run_op(16'd3, 16'd5, 5, 0);
    tick();
    check("poke_no_restart", busy, 0);

    // Abort mid-CALC: no done may follow.
    run_op(16'd100, 16'd200, 0, 8);
    for (int i = 0; i < M + 2; i++) begin
      tick();
      check("no_done_after_abort", done, 0);
      check("idle_after_abort", busy, 0);
    end

    // Back-to-back: each new start lands on the previous done cycle.
    run_op(16'h1234, 16'h5678, 0, 0);
    run_op(16'hABCD, 16'h0F0F, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_op(N'($urandom), M'($urandom), 0, 0);
    end
    tick();
    check("idle_after_burst", ready, 1);
    check("no_done_after_burst", done, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_shift_add_multiplier
